// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: NCH synchronised input channels, NCH output registers,
// per-channel change status (write-1-to-clear), and a maskable registered interrupt.
module gpio_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AW          = $clog2(2*NCH+2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        a,
  input  logic                 we,
  input  logic [WIDTH-1:0]     wd,
  output logic [WIDTH-1:0]     rd,
  input  logic [NCH*WIDTH-1:0] gpi,
  output logic [NCH*WIDTH-1:0] gpo,
  output logic                 irq
);

  localparam int unsigned BW     = NCH * WIDTH;
  localparam int unsigned STAT_A = 2 * NCH;
  localparam int unsigned MASK_A = 2 * NCH + 1;

  logic [BW-1:0]  sync_q [SYNC_STAGES];
  logic [BW-1:0]  in_sync;
  logic [BW-1:0]  prev_q;
  logic [BW-1:0]  out_q;
  logic [BW-1:0]  out_d;
  logic [NCH-1:0] stat_q;
  logic [NCH-1:0] stat_d;
  logic [NCH-1:0] mask_q;
  logic [NCH-1:0] mask_d;
  logic [NCH-1:0] change;
  logic [NCH-1:0] clr;
  logic           irq_q;
  logic           irq_d;

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign gpo     = out_q;
  assign irq     = irq_q;

  // Per-channel change detect against last cycle's synchronised value
  always_comb begin
    change = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      change[i] = (in_sync[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]);
    end
  end

  // Next-state: register writes, W1C status (set wins), irq from next-state values
  always_comb begin
    out_d  = out_q;
    clr    = '0;
    mask_d = mask_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (we && (a == AW'(NCH + i))) begin
        out_d[i*WIDTH +: WIDTH] = wd;
      end
    end
    if (we && (a == AW'(STAT_A))) begin
      clr = wd[NCH-1:0];
    end
    if (we && (a == AW'(MASK_A))) begin
      mask_d = wd[NCH-1:0];
    end
    stat_d = change | (stat_q & ~clr);
    irq_d  = |(stat_d & mask_d);
  end

  // Read mux, combinational from address and registered state
  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (a == AW'(i)) begin
        rd = in_sync[i*WIDTH +: WIDTH];
      end
      if (a == AW'(NCH + i)) begin
        rd = out_q[i*WIDTH +: WIDTH];
      end
    end
    if (a == AW'(STAT_A)) begin
      rd = WIDTH'(stat_q);
    end
    if (a == AW'(MASK_A)) begin
      rd = WIDTH'(mask_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
      out_q  <= '0;
      stat_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q[0] <= gpi;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= in_sync;
      out_q  <= out_d;
      stat_q <= stat_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: stimulus queues expected values, a negedge monitor checks them.
module tb_gpio_bank;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NCH   = 4;
  localparam int unsigned SS    = 2;
  localparam int unsigned AW    = $clog2(2*NCH+2);
  localparam int unsigned BW    = NCH * WIDTH;

  localparam int K_RD  = 0;
  localparam int K_GPO = 1;
  localparam int K_IRQ = 2;

  typedef struct {
    int          kind;
    logic [BW-1:0] exp;
    string       name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     a;
  logic              we;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  rd;
  logic [BW-1:0]     gpi;
  logic [BW-1:0]     gpo;
  logic              irq;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  gpio_bank #(.WIDTH(WIDTH), .NCH(NCH), .SYNC_STAGES(SS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .we(we), .wd(wd), .rd(rd),
    .gpi(gpi), .gpo(gpo), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: drains expectations pushed in this cycle, sampling mid-cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [BW-1:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RD:    act = BW'(rd);
        K_GPO:   act = gpo;
        default: act = BW'(irq);
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [BW-1:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic wr(input int addr, input logic [WIDTH-1:0] data);
    we = 1'b1;
    a  = AW'(addr);
    wd = data;
    step();
    we = 1'b0;
  endtask

  task automatic rd_chk(input int addr, input logic [WIDTH-1:0] exp, input string name);
    a = AW'(addr);
    push(K_RD, BW'(exp), name);
  endtask

  logic [BW-1:0] gpo_exp;

  initial begin
    rst_n = 1'b0;
    a     = '0;
    we    = 1'b0;
    wd    = '0;
    gpi   = '0;
    gpo_exp = '0;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    push(K_GPO, '0, "rst_gpo");
    push(K_IRQ, '0, "rst_irq");
    for (int i = 0; i < 10; i++) begin
      rd_chk(i, '0, $sformatf("rst_rd_a%0d", i));
      step();
    end

    // Output write / readback
    wr(5, 32'hDEAD_BEEF);
    gpo_exp[63:32] = 32'hDEAD_BEEF;
    push(K_GPO, gpo_exp, "gpo_after_write");
    rd_chk(5, 32'hDEAD_BEEF, "out1_readback");
    step();
    wr(0, 32'hFFFF_FFFF);
    push(K_GPO, gpo_exp, "in_write_ignored_gpo");
    rd_chk(0, '0, "in_write_ignored_rd");
    step();
    // Read in the cycle of a write returns the old value
    we = 1'b1; a = AW'(6); wd = 32'h0000_55AA;
    push(K_RD, '0, "read_during_write_old");
    step();
    we = 1'b0;
    gpo_exp[95:64] = 32'h0000_55AA;
    push(K_GPO, gpo_exp, "gpo_ch2_write");
    rd_chk(6, 32'h0000_55AA, "out2_readback");
    step();
    wr(9, 32'hFFFF_FFF0);
    rd_chk(9, '0, "mask_upper_ignored");
    step();
    wr(12, 32'h1234_5678);
    rd_chk(12, '0, "unmapped_reads_zero");
    push(K_GPO, gpo_exp, "unmapped_write_gpo");
    step();

    // Input sync latency
    gpi[95:64] = 32'h0000_1234;
    step();
    rd_chk(2, '0, "in_not_yet_e0");
    step();
    rd_chk(2, 32'h0000_1234, "in_sync_e0p1");
    step();
    rd_chk(8, 32'h4, "stat_set_e0p2");
    push(K_IRQ, '0, "irq_masked_off");
    step();
    wr(8, 32'h4);
    rd_chk(8, '0, "stat_cleared");
    step();

    // Interrupt and W1C
    wr(9, 32'h4);
    rd_chk(9, 32'h4, "mask_readback");
    gpi[95:64] = 32'h0000_1235;
    step();
    push(K_IRQ, '0, "irq_low_e0");
    step();
    push(K_IRQ, '0, "irq_low_e0p1");
    step();
    push(K_IRQ, 1, "irq_high_e0p2");
    rd_chk(8, 32'h4, "stat_e0p2");
    step();
    wr(8, 32'h0);
    push(K_IRQ, 1, "w1c_zero_irq_kept");
    rd_chk(8, 32'h4, "w1c_zero_stat_kept");
    step();
    wr(8, 32'h4);
    push(K_IRQ, '0, "w1c_irq_cleared");
    rd_chk(8, '0, "w1c_stat_cleared");
    step();

    // Set/clear collision: set wins
    wr(9, 32'h6);
    gpi[63:32] = 32'h0000_000A;
    step();
    step();
    wr(8, 32'h2);
    push(K_IRQ, 1, "collision_irq");
    rd_chk(8, 32'h2, "collision_stat");
    step();
    wr(8, 32'h2);
    push(K_IRQ, '0, "collision_later_clear");
    step();
    // Re-raise irq through a channel-2 change ahead of the reset test
    gpi[95:64] = 32'h0000_0000;
    step();
    step();
    step();
    push(K_IRQ, 1, "irq_before_reset");
    push(K_GPO, gpo_exp, "gpo_before_reset");
    step();

    // Async reset mid-operation
    rst_n = 1'b0;
    #1;
    push(K_IRQ, '0, "async_rst_irq");
    push(K_GPO, '0, "async_rst_gpo");
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    rd_chk(8, 32'h2, "release_stat_from_gpi");
    push(K_IRQ, '0, "release_irq_masked");
    step();
    rd_chk(9, '0, "release_mask_zero");
    step();
    rd_chk(5, '0, "release_out_zero");
    step();
    step();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
